alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter OP_W, default 12, the one-hot ALU operation width (bit order: add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui; bit 0 = add).
REQ-002 SHALL have port clk, input, 1, the single clock; all state on the rising edge.
REQ-003 SHALL have port resetn, input, 1, reset; asynchronous assert, active-low.
REQ-004 SHALL have port flush, input, 1, synchronous discard of all held entries.
REQ-005 SHALL have ports in_valid (input, 1), in_ready (output, 1), the decode-side handshake.
REQ-006 SHALL have port in_inst, input, 32, the LA32 instruction word.
REQ-007 SHALL have ports in_rj_value and in_rkd_value, input, 32 each, the register-file read data.
REQ-008 SHALL have ports out_valid (output, 1), out_ready (input, 1), the execute-side handshake.
REQ-009 SHALL have ports out_alu_op (output, OP_W), out_alu_src1 and out_alu_src2 (output, 32 each), the ALU operands.
REQ-010 SHALL have ports out_dest (output, 5, rd field), out_gr_we (output, 1), out_ill (output, 1, unsupported opcode).

Function
REQ-011 SHALL transfer on in_valid&in_ready and on out_valid&out_ready; no other condition moves data.
REQ-012 SHALL decode inst[31:15]: 0x00020 add.w, 0x00022 sub.w, 0x00024 slt, 0x00025 sltu, 0x00028 nor, 0x00029 and, 0x0002a or, 0x0002b xor, 0x0002e sll.w, 0x0002f srl.w, 0x00030 sra.w; src1=rj, src2=rkd.
REQ-013 SHALL decode inst[31:15] 0x00081 slli.w, 0x00089 srli.w, 0x00091 srai.w; src2={27'b0,inst[14:10]}.
REQ-014 SHALL decode inst[31:22] 0x00a addi.w, 0x008 slti, 0x009 sltui with src2=sign-extended inst[21:10]; 0x00d andi, 0x00e ori, 0x00f xori with src2=zero-extended inst[21:10].
REQ-015 SHALL decode inst[31:25]=0x0a lu12i.w as op lui, src2={inst[24:5],12'b0}, src1=0.
REQ-016 SHALL set exactly one alu_op bit and out_gr_we=1 for every supported opcode; out_dest=inst[4:0].
REQ-017 SHALL, for any other opcode, emit out_ill=1, out_alu_op=0, out_gr_we=0, sources 0; entry still flows through the handshake.
REQ-018 SHALL register all outputs; latency in-accept to out_valid = 1 cycle.
REQ-019 SHALL preserve entry order; no loss or duplication under any out_ready pattern.
REQ-020 SHALL, when flush=1, clear all entries next edge, hold in_ready=0 that cycle; flush wins over simultaneous accept.
REQ-021 SHALL, when full and output drained in the same cycle, accept new input that cycle (when in_ready permits per REQ-026/027).

Reset
REQ-022 SHALL on resetn=0 immediately force out_valid=0, in_ready=0, out_alu_op=0, sources 0, out_dest=0, out_gr_we=0, out_ill=0.
REQ-023 SHALL raise in_ready the first cycle after resetn deasserts; entries in flight at reset are discarded.

Configuration
REQ-024 SHALL use macro ALU_ISSUE_SKID_EN.
REQ-025 SHALL, with ALU_ISSUE_SKID_EN defined, hold a 2-entry skid buffer, states EMPTY/ONE/TWO; in_ready registered = (state!=TWO).
REQ-026 SHALL, in EMPTY: accept->ONE; ONE: accept&!drain->TWO, drain&!accept->EMPTY, else ONE; TWO: drain->ONE.
REQ-027 SHALL, without the macro, hold a single register; in_ready = !out_valid | out_ready (combinational).

Structure
REQ-028 SHALL place opcode constants, OP_W and alu_op bit-index constants in shared package alu_pkg, also used by the ALU.
REQ-029 SHALL implement decode as combinational sub-module alu_issue_dec (inst, rj, rkd -> op, src1, src2, dest, gr_we, ill).

Verification
REQ-030 SHALL cover: add.w rj=5, rkd=3 -> next cycle out_valid=1, alu_op=0x001, src1=5, src2=3.
REQ-031 SHALL cover: lu12i.w si20=0x12345, rd=7 -> alu_op=0x800, src2=0x12345000, dest=7.
REQ-032 SHALL cover: addi.w si12=0xFFF -> src2=0xFFFFFFFF; andi ui12=0xFFF -> src2=0x00000FFF, alu_op=0x010.
REQ-033 SHALL cover: skid on, out_ready=0 three cycles, in_valid held -> exactly 2 accepted, in_ready=0, drained in order after out_ready=1.
REQ-034 SHALL cover: inst=0xFFFFFFFF -> out_ill=1, alu_op=0, gr_we=0; flush with TWO entries -> out_valid=0 next cycle.
REQ-035 SHALL cover: resetn low mid-stream -> out_valid=0 immediately; first post-reset output is first post-reset input.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU constants: one-hot op bit indices, LA32 opcodes, issue entry.
// Also used by the execute-stage ALU.
package alu_pkg;

  localparam int OP_W = 12;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_SLT  = 2;
  localparam int OP_SLTU = 3;
  localparam int OP_AND  = 4;
  localparam int OP_NOR  = 5;
  localparam int OP_OR   = 6;
  localparam int OP_XOR  = 7;
  localparam int OP_SLL  = 8;
  localparam int OP_SRL  = 9;
  localparam int OP_SRA  = 10;
  localparam int OP_LUI  = 11;

  localparam logic [16:0] OPC_ADD_W  = 17'h00020;
  localparam logic [16:0] OPC_SUB_W  = 17'h00022;
  localparam logic [16:0] OPC_SLT    = 17'h00024;
  localparam logic [16:0] OPC_SLTU   = 17'h00025;
  localparam logic [16:0] OPC_NOR    = 17'h00028;
  localparam logic [16:0] OPC_AND    = 17'h00029;
  localparam logic [16:0] OPC_OR     = 17'h0002a;
  localparam logic [16:0] OPC_XOR    = 17'h0002b;
  localparam logic [16:0] OPC_SLL_W  = 17'h0002e;
  localparam logic [16:0] OPC_SRL_W  = 17'h0002f;
  localparam logic [16:0] OPC_SRA_W  = 17'h00030;
  localparam logic [16:0] OPC_SLLI_W = 17'h00081;
  localparam logic [16:0] OPC_SRLI_W = 17'h00089;
  localparam logic [16:0] OPC_SRAI_W = 17'h00091;

  localparam logic [9:0] OPC_SLTI   = 10'h008;
  localparam logic [9:0] OPC_SLTUI  = 10'h009;
  localparam logic [9:0] OPC_ADDI_W = 10'h00a;
  localparam logic [9:0] OPC_ANDI   = 10'h00d;
  localparam logic [9:0] OPC_ORI    = 10'h00e;
  localparam logic [9:0] OPC_XORI   = 10'h00f;

  localparam logic [6:0] OPC_LU12I_W = 7'h0a;

  typedef logic [OP_W-1:0] alu_op_t;

  typedef struct packed {
    alu_op_t     op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  dest;
    logic        gr_we;
    logic        ill;
  } alu_ent_t;

  function automatic alu_op_t op_bit(input int idx);
    return alu_op_t'(1) << idx;
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Execute-side issue bundle: valid/ready handshake plus ALU operands.
interface alu_issue_if;
  import alu_pkg::*;

  logic        valid;
  logic        ready;
  alu_op_t     alu_op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [4:0]  dest;
  logic        gr_we;
  logic        ill;

  modport master (
    output valid, alu_op, src1, src2,
    output dest, gr_we, ill,
    input  ready
  );

  modport slave (
    input  valid, alu_op, src1, src2,
    input  dest, gr_we, ill,
    output ready
  );
endinterface

// File: rtl/alu_issue_dec.sv
// Combinational LA32 ALU decode: instruction + register data to
// one-hot op and operands; unknown opcodes produce an all-zero ill entry.
module alu_issue_dec
  import alu_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] rj,
  input  logic [31:0] rkd,
  output alu_op_t     op,
  output logic [31:0] src1,
  output logic [31:0] src2,
  output logic [4:0]  dest,
  output logic        gr_we,
  output logic        ill
);

  typedef enum logic [2:0] {
    S_NONE, S_RK, S_UI5, S_SI12, S_UI12, S_LUI
  } src_t;

  logic [16:0] op17;
  logic [9:0]  op10;
  logic [6:0]  op7;
  src_t        sk;

  assign op17 = inst[31:15];
  assign op10 = inst[31:22];
  assign op7  = inst[31:25];

  always_comb begin
    op = '0;
    sk = S_NONE;
    unique case (1'b1)
      op17 == OPC_ADD_W:  begin op = op_bit(OP_ADD);  sk = S_RK;   end
      op17 == OPC_SUB_W:  begin op = op_bit(OP_SUB);  sk = S_RK;   end
      op17 == OPC_SLT:    begin op = op_bit(OP_SLT);  sk = S_RK;   end
      op17 == OPC_SLTU:   begin op = op_bit(OP_SLTU); sk = S_RK;   end
      op17 == OPC_NOR:    begin op = op_bit(OP_NOR);  sk = S_RK;   end
      op17 == OPC_AND:    begin op = op_bit(OP_AND);  sk = S_RK;   end
      op17 == OPC_OR:     begin op = op_bit(OP_OR);   sk = S_RK;   end
      op17 == OPC_XOR:    begin op = op_bit(OP_XOR);  sk = S_RK;   end
      op17 == OPC_SLL_W:  begin op = op_bit(OP_SLL);  sk = S_RK;   end
      op17 == OPC_SRL_W:  begin op = op_bit(OP_SRL);  sk = S_RK;   end
      op17 == OPC_SRA_W:  begin op = op_bit(OP_SRA);  sk = S_RK;   end
      op17 == OPC_SLLI_W: begin op = op_bit(OP_SLL);  sk = S_UI5;  end
      op17 == OPC_SRLI_W: begin op = op_bit(OP_SRL);  sk = S_UI5;  end
      op17 == OPC_SRAI_W: begin op = op_bit(OP_SRA);  sk = S_UI5;  end
      op10 == OPC_ADDI_W: begin op = op_bit(OP_ADD);  sk = S_SI12; end
      op10 == OPC_SLTI:   begin op = op_bit(OP_SLT);  sk = S_SI12; end
      op10 == OPC_SLTUI:  begin op = op_bit(OP_SLTU); sk = S_SI12; end
      op10 == OPC_ANDI:   begin op = op_bit(OP_AND);  sk = S_UI12; end
      op10 == OPC_ORI:    begin op = op_bit(OP_OR);   sk = S_UI12; end
      op10 == OPC_XORI:   begin op = op_bit(OP_XOR);  sk = S_UI12; end
      op7 == OPC_LU12I_W: begin op = op_bit(OP_LUI);  sk = S_LUI;  end
      default: ;
    endcase
  end

  always_comb begin
    src1 = rj;
    src2 = '0;
    unique case (sk)
      S_RK:    src2 = rkd;
      S_UI5:   src2 = {27'b0, inst[14:10]};
      S_SI12:  src2 = {{20{inst[21]}}, inst[21:10]};
      S_UI12:  src2 = {20'b0, inst[21:10]};
      S_LUI:   begin src1 = '0; src2 = {inst[24:5], 12'b0}; end
      default: src1 = '0;
    endcase
  end

  assign ill   = (sk == S_NONE);
  assign gr_we = ~ill;
  assign dest  = ill ? 5'd0 : inst[4:0];

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decode, then hold entries toward execute.
// ALU_ISSUE_SKID_EN selects a 2-entry skid buffer over a single register.
module alu_issue #(
  parameter int OP_W = alu_pkg::OP_W
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [31:0]     in_rj_value,
  input  logic [31:0]     in_rkd_value,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] out_alu_op,
  output logic [31:0]     out_alu_src1,
  output logic [31:0]     out_alu_src2,
  output logic [4:0]      out_dest,
  output logic            out_gr_we,
  output logic            out_ill
);
  import alu_pkg::*;

  alu_ent_t dec_e;
  alu_ent_t head;
  logic     vld_q;
  logic     accept;
  logic     drain;

  alu_issue_dec u_dec (
    .inst  (in_inst),
    .rj    (in_rj_value),
    .rkd   (in_rkd_value),
    .op    (dec_e.op),
    .src1  (dec_e.src1),
    .src2  (dec_e.src2),
    .dest  (dec_e.dest),
    .gr_we (dec_e.gr_we),
    .ill   (dec_e.ill)
  );

  assign accept = in_valid & in_ready;
  assign drain  = vld_q & out_ready;

`ifdef ALU_ISSUE_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t   state;
  alu_ent_t tail;
  logic     rdy_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
      vld_q <= 1'b0;
      rdy_q <= 1'b0;
    end else if (flush) begin
      state <= EMPTY;
      vld_q <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      rdy_q <= 1'b1;
      unique case (state)
        EMPTY: if (accept) begin
          head  <= dec_e;
          vld_q <= 1'b1;
          state <= ONE;
        end
        ONE: begin
          if (accept && drain) begin
            head <= dec_e;
          end else if (accept) begin
            tail  <= dec_e;
            state <= TWO;
            rdy_q <= 1'b0;
          end else if (drain) begin
            vld_q <= 1'b0;
            state <= EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            head  <= tail;
            state <= ONE;
          end else begin
            rdy_q <= 1'b0;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign in_ready = rdy_q & ~flush;
`else
  // rdy_en keeps in_ready low until the first edge after reset
  logic rdy_en;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head   <= '0;
      vld_q  <= 1'b0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (flush) begin
        vld_q <= 1'b0;
      end else if (accept) begin
        head  <= dec_e;
        vld_q <= 1'b1;
      end else if (drain) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign in_ready = rdy_en & ~flush & (~vld_q | out_ready);
`endif

  assign out_valid    = vld_q;
  assign out_alu_op   = OP_W'(head.op);
  assign out_alu_src1 = head.src1;
  assign out_alu_src2 = head.src2;
  assign out_dest     = head.dest;
  assign out_gr_we    = head.gr_we;
  assign out_ill      = head.ill;

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue (both buffer builds).
`timescale 1ns/1ps
module tb_alu_issue;
  logic        clk;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_rj_value;
  logic [31:0] in_rkd_value;

  int checks;
  int failures;

  alu_issue_if ex_if ();

  alu_issue #(.OP_W(12)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst      (in_inst),
    .in_rj_value  (in_rj_value),
    .in_rkd_value (in_rkd_value),
    .out_valid    (ex_if.valid),
    .out_ready    (ex_if.ready),
    .out_alu_op   (ex_if.alu_op),
    .out_alu_src1 (ex_if.src1),
    .out_alu_src2 (ex_if.src2),
    .out_dest     (ex_if.dest),
    .out_gr_we    (ex_if.gr_we),
    .out_ill      (ex_if.ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r3(input logic [16:0] op);
    return {op, 5'd3, 5'd2, 5'd9};
  endfunction

  function automatic logic [31:0] sh(input logic [16:0] op, input logic [4:0] sa);
    return {op, sa, 5'd2, 5'd9};
  endfunction

  function automatic logic [31:0] i12(input logic [9:0] op, input logic [11:0] imm);
    return {op, imm, 5'd2, 5'd9};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one entry, wait (bounded) for in_ready, hold for one edge.
  task automatic drive_one(input logic [31:0] inst, input logic [31:0] rj, input logic [31:0] rkd);
    int n;
    n = 0;
    in_inst = inst;
    in_rj_value = rj;
    in_rkd_value = rkd;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL drive_timeout: in_ready=%0b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #1;
    checks++;
    if (ex_if.valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: valid=%0b ready=%0b required 0/0", ex_if.valid, in_ready);
    end
    checks++;
    if (ex_if.alu_op !== 12'h0 || ex_if.src1 !== 32'h0 || ex_if.src2 !== 32'h0 ||
        ex_if.dest !== 5'd0 || ex_if.gr_we !== 1'b0 || ex_if.ill !== 1'b0) begin
      failures++;
      $display("FAIL reset_data: op=%h s1=%h s2=%h d=%0d we=%0b ill=%0b required all 0",
               ex_if.alu_op, ex_if.src1, ex_if.src2, ex_if.dest, ex_if.gr_we, ex_if.ill);
    end
    step();
    resetn = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_rdy_pre: in_ready=%0b required 0", in_ready);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || ex_if.valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_rdy_post: ready=%0b valid=%0b required 1/0", in_ready, ex_if.valid);
    end
  endtask

  task automatic test_add();
    ex_if.ready = 1'b1;
    drive_one({17'h00020, 5'd3, 5'd2, 5'd1}, 32'd5, 32'd3);
    checks++;
    if (ex_if.valid !== 1'b1 || ex_if.alu_op !== 12'h001) begin
      failures++;
      $display("FAIL add_op: valid=%0b op=%h required 1/001", ex_if.valid, ex_if.alu_op);
    end
    checks++;
    if (ex_if.src1 !== 32'd5 || ex_if.src2 !== 32'd3) begin
      failures++;
      $display("FAIL add_src: s1=%h s2=%h required 5/3", ex_if.src1, ex_if.src2);
    end
    checks++;
    if (ex_if.dest !== 5'd1 || ex_if.gr_we !== 1'b1 || ex_if.ill !== 1'b0) begin
      failures++;
      $display("FAIL add_ctl: d=%0d we=%0b ill=%0b required 1/1/0", ex_if.dest, ex_if.gr_we, ex_if.ill);
    end
    step();
    checks++;
    if (ex_if.valid !== 1'b0) begin
      failures++;
      $display("FAIL add_drain: valid=%0b required 0", ex_if.valid);
    end
  endtask

  task automatic test_lui();
    ex_if.ready = 1'b1;
    drive_one({7'h0a, 20'h12345, 5'd7}, 32'hdead_beef, 32'h1);
    checks++;
    if (ex_if.alu_op !== 12'h800 || ex_if.src2 !== 32'h1234_5000) begin
      failures++;
      $display("FAIL lui_op: op=%h s2=%h required 800/12345000", ex_if.alu_op, ex_if.src2);
    end
    checks++;
    if (ex_if.src1 !== 32'h0 || ex_if.dest !== 5'd7 || ex_if.gr_we !== 1'b1) begin
      failures++;
      $display("FAIL lui_ctl: s1=%h d=%0d we=%0b required 0/7/1", ex_if.src1, ex_if.dest, ex_if.gr_we);
    end
    step();
  endtask

  task automatic test_decode();
    logic [31:0] ins [20];
    logic [11:0] eop [20];
    logic [31:0] es2 [20];
    ins[0]  = r3(17'h00022);        eop[0]  = 12'h002; es2[0]  = 32'h22;
    ins[1]  = r3(17'h00025);        eop[1]  = 12'h008; es2[1]  = 32'h22;
    ins[2]  = r3(17'h00028);        eop[2]  = 12'h020; es2[2]  = 32'h22;
    ins[3]  = r3(17'h00030);        eop[3]  = 12'h400; es2[3]  = 32'h22;
    ins[4]  = sh(17'h00081, 5'd4);  eop[4]  = 12'h100; es2[4]  = 32'd4;
    ins[5]  = sh(17'h00091, 5'd31); eop[5]  = 12'h400; es2[5]  = 32'd31;
    ins[6]  = i12(10'h00a, 12'hfff); eop[6] = 12'h001; es2[6]  = 32'hffff_ffff;
    ins[7]  = i12(10'h00d, 12'hfff); eop[7] = 12'h010; es2[7]  = 32'h0000_0fff;
    ins[8]  = i12(10'h008, 12'h800); eop[8] = 12'h004; es2[8]  = 32'hffff_f800;
    ins[9]  = i12(10'h009, 12'h7ff); eop[9] = 12'h008; es2[9]  = 32'h0000_07ff;
    ins[10] = i12(10'h00e, 12'h800); eop[10] = 12'h040; es2[10] = 32'h0000_0800;
    ins[11] = i12(10'h00f, 12'h123); eop[11] = 12'h080; es2[11] = 32'h0000_0123;
    ins[12] = r3(17'h00024);        eop[12] = 12'h004; es2[12] = 32'h22;
    ins[13] = r3(17'h00029);        eop[13] = 12'h010; es2[13] = 32'h22;
    ins[14] = r3(17'h0002a);        eop[14] = 12'h040; es2[14] = 32'h22;
    ins[15] = r3(17'h0002b);        eop[15] = 12'h080; es2[15] = 32'h22;
    ins[16] = r3(17'h0002e);        eop[16] = 12'h100; es2[16] = 32'h22;
    ins[17] = r3(17'h0002f);        eop[17] = 12'h200; es2[17] = 32'h22;
    ins[18] = sh(17'h00089, 5'd1);  eop[18] = 12'h200; es2[18] = 32'd1;
    ins[19] = r3(17'h00020);        eop[19] = 12'h001; es2[19] = 32'h22;
    ex_if.ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_one(ins[i], 32'h11, 32'h22);
      checks++;
      if (ex_if.alu_op !== eop[i] || ex_if.src2 !== es2[i]) begin
        failures++;
        $display("FAIL dec_%0d: op=%h s2=%h required %h/%h", i, ex_if.alu_op, ex_if.src2, eop[i], es2[i]);
      end
      checks++;
      if (ex_if.src1 !== 32'h11 || ex_if.dest !== 5'd9 || ex_if.gr_we !== 1'b1 || ex_if.ill !== 1'b0) begin
        failures++;
        $display("FAIL dec_ctl_%0d: s1=%h d=%0d we=%0b ill=%0b required 11/9/1/0",
                 i, ex_if.src1, ex_if.dest, ex_if.gr_we, ex_if.ill);
      end
    end
    step();
  endtask

  task automatic test_backpressure();
    int acc;
    int exp_acc;
    logic take;
`ifdef ALU_ISSUE_SKID_EN
    exp_acc = 2;
`else
    exp_acc = 1;
`endif
    acc = 0;
    ex_if.ready = 1'b0;
    in_inst = r3(17'h00020);
    in_rkd_value = 32'h0;
    in_rj_value = 32'd100;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      take = in_ready;
      step();
      if (take) begin
        acc++;
        in_rj_value = 32'd100 + 32'(acc);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (acc != exp_acc || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept: accepted=%0d ready=%0b required %0d/0", acc, in_ready, exp_acc);
    end
    checks++;
    if (ex_if.valid !== 1'b1 || ex_if.src1 !== 32'd100) begin
      failures++;
      $display("FAIL bp_head: valid=%0b s1=%0d required 1/100", ex_if.valid, ex_if.src1);
    end
    ex_if.ready = 1'b1;
    step();
`ifdef ALU_ISSUE_SKID_EN
    checks++;
    if (ex_if.valid !== 1'b1 || ex_if.src1 !== 32'd101) begin
      failures++;
      $display("FAIL bp_second: valid=%0b s1=%0d required 1/101", ex_if.valid, ex_if.src1);
    end
    step();
`endif
    checks++;
    if (ex_if.valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_empty: valid=%0b required 0", ex_if.valid);
    end
  endtask

  task automatic test_back_to_back();
    ex_if.ready = 1'b1;
    in_inst = r3(17'h0002a);
    in_rkd_value = 32'h0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_rj_value = 32'd200 + 32'(i);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready_%0d: ready=%0b required 1", i, in_ready);
      end
      step();
      checks++;
      if (ex_if.valid !== 1'b1 || ex_if.src1 !== 32'd200 + 32'(i)) begin
        failures++;
        $display("FAIL b2b_out_%0d: valid=%0b s1=%0d required 1/%0d", i, ex_if.valid, ex_if.src1, 200 + i);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (ex_if.valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_empty: valid=%0b required 0", ex_if.valid);
    end
  endtask

  task automatic test_illegal();
    ex_if.ready = 1'b1;
    drive_one(32'hffff_ffff, 32'd5, 32'd6);
    checks++;
    if (ex_if.valid !== 1'b1 || ex_if.ill !== 1'b1) begin
      failures++;
      $display("FAIL ill_flag: valid=%0b ill=%0b required 1/1", ex_if.valid, ex_if.ill);
    end
    checks++;
    if (ex_if.alu_op !== 12'h0 || ex_if.gr_we !== 1'b0 || ex_if.src1 !== 32'h0 || ex_if.src2 !== 32'h0) begin
      failures++;
      $display("FAIL ill_data: op=%h we=%0b s1=%h s2=%h required 0/0/0/0",
               ex_if.alu_op, ex_if.gr_we, ex_if.src1, ex_if.src2);
    end
    step();
  endtask

  task automatic test_flush();
    ex_if.ready = 1'b0;
    in_inst = r3(17'h00020);
    in_rkd_value = 32'h0;
    in_rj_value = 32'h300;
    in_valid = 1'b1;
    step();
    in_rj_value = 32'h301;
    step();
    checks++;
    if (ex_if.valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_full: valid=%0b ready=%0b required 1/0", ex_if.valid, in_ready);
    end
    flush = 1'b1;
    in_rj_value = 32'h302;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_rdy: ready=%0b required 0", in_ready);
    end
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (ex_if.valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_clear: valid=%0b ready=%0b required 0/1", ex_if.valid, in_ready);
    end
    ex_if.ready = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    ex_if.ready = 1'b0;
    in_inst = r3(17'h00020);
    in_rkd_value = 32'h0;
    in_rj_value = 32'h400;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (ex_if.valid !== 1'b0 || in_ready !== 1'b0 || ex_if.src1 !== 32'h0 || ex_if.alu_op !== 12'h0) begin
      failures++;
      $display("FAIL rst_mid: valid=%0b ready=%0b s1=%h op=%h required 0/0/0/0",
               ex_if.valid, in_ready, ex_if.src1, ex_if.alu_op);
    end
    step();
    resetn = 1'b1;
    step();
    checks++;
    if (ex_if.valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_stale: valid=%0b required 0", ex_if.valid);
    end
    ex_if.ready = 1'b1;
    drive_one(r3(17'h00020), 32'h77, 32'h1);
    checks++;
    if (ex_if.valid !== 1'b1 || ex_if.src1 !== 32'h77) begin
      failures++;
      $display("FAIL rst_first: valid=%0b s1=%h required 1/77", ex_if.valid, ex_if.src1);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    resetn = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_inst = '0;
    in_rj_value = '0;
    in_rkd_value = '0;
    ex_if.ready = 1'b0;
    test_reset();
    test_add();
    test_lui();
    test_decode();
    test_backpressure();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
